// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   state_t      : fetch FSM state encoding (2 bits)
//   OPC_W        : width of the opcode field handed to decoder3_8
//   HALT_OPC_DEF : default opcode that stops fetching once consumed
//   opcode_of()  : pulls the opcode field (top OPC_W bits) out of an
//                  instruction word of arbitrary width up to 64 bits
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] HALT_OPC_DEF = 3'b111;

    // The word is passed zero-extended to 64 bits together with its real
    // width, so one function serves every INSTR_W the stage is built with.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [63:0] word,
                                                   input int          instr_w);
        return word[instr_w-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage feeding the 3-to-8 opcode decoder.
// Owns the PC, fetches over a REQ/ACK handshake, holds the word in IR until
// the execute side consumes it, and stops for good after a HALT opcode.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   imem_req   out  fetch request (high in FETCH)
//   imem_addr  out  fetch address (= PC)
//   imem_ack   in   imem_data valid this cycle
//   imem_data  in   instruction word
//   adv        in   execute side consumes the held instruction
//   br_taken   in   redirect fetch to br_target
//   br_target  in   redirect address
//   ir         out  instruction register
//   ir_valid   out  IR holds an unconsumed instruction
//   opc        out  opcode field of IR while valid, else 0 (to decoder ENC)
//   halted     out  fetch stopped
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               PC_W     = 7,
    parameter int               INSTR_W  = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               adv,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [OPC_W-1:0]   opc,
    output logic               halted
);

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [OPC_W-1:0]   ir_opc;

    assign ir_opc = opcode_of(64'(ir_reg), INSTR_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // Branch redirect outranks both ACK and ADV: a word returned in the same
    // cycle belongs to the wrong path and is dropped without touching IR.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (br_taken) begin
                    pc_next    = br_target;
                    state_next = ST_FETCH;
                end else if (imem_ack) begin
                    ir_next    = imem_data;
                    pc_next    = pc_reg + PC_W'(1);  // wraps all-ones -> 0
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (br_taken) begin
                    pc_next    = br_target;
                    state_next = ST_FETCH;
                end else if (adv) begin
                    state_next = (ir_opc == HALT_OPC) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore decodes; opc depends only on IR and state so no input reaches it.
    assign imem_req  = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg;
    assign ir        = ir_reg;
    assign ir_valid  = (state_reg == ST_HOLD);
    assign halted    = (state_reg == ST_HALT);
    assign opc       = ir_valid ? ir_opc : '0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [6:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       adv;
    logic       br_taken;
    logic [6:0] br_target;
    logic [7:0] ir;
    logic       ir_valid;
    logic [2:0] opc;
    logic       halted;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [6:0] exp_pc;
    logic [7:0] last_ir;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_W     (7),
        .INSTR_W  (8),
        .RESET_PC (7'd0),
        .HALT_OPC (3'b111)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .adv       (adv),
        .br_taken  (br_taken),
        .br_target (br_target),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .opc       (opc),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Complete one fetch at exp_pc after 'waits' idle cycles; lands in HOLD.
    task automatic do_fetch(input logic [7:0] data, input int waits);
        logic [7:0] e;
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, exp_pc);
            step();
        end
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, exp_pc);
        imem_ack  = 1'b1;
        imem_data = data;
        exp_q.push_back(data);
        step();
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        exp_pc    = exp_pc + 7'd1;
        e         = exp_q.pop_front();
        last_ir   = e;
        chk("hold_valid", ir_valid, 1'b1);
        chk("hold_ir", ir, e);
        chk("hold_opc", opc, e >> 5);
        chk("hold_req", imem_req, 1'b0);
        chk("hold_pc", imem_addr, exp_pc);
        $display("fetch data=%02h -> ir=%02h opc=%0d next_pc=%02h", data, ir, opc, exp_pc);
    endtask

    task automatic do_adv();
        adv = 1'b1;
        step();
        adv = 1'b0;
        chk("adv_valid", ir_valid, 1'b0);
        chk("adv_opc", opc, 3'b000);
        $display("adv -> req=%0b addr=%02h halted=%0b", imem_req, imem_addr, halted);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        adv       = 1'b0;
        br_taken  = 1'b0;
        br_target = 7'h00;
        exp_pc    = 7'd0;
        last_ir   = 8'h00;

        // Reset values
        #3;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_ir", ir, 8'h00);
        chk("rst_opc", opc, 3'b000);
        chk("rst_halted", halted, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        chk("idle_req", imem_req, 1'b0);
        step();
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 7'd0);
        chk("first_opc", opc, 3'b000);
        $display("reset released -> req=%0b addr=%02h", imem_req, imem_addr);

        // First fetch after a 3-cycle memory wait
        do_fetch(8'h5A, 3);
        do_adv();
        chk("adv_req", imem_req, 1'b1);
        chk("adv_addr", imem_addr, 7'd1);

        // ADV with nothing held is ignored
        adv = 1'b1;
        step();
        adv = 1'b0;
        chk("adv_idle_req", imem_req, 1'b1);
        chk("adv_idle_addr", imem_addr, 7'd1);

        // Walk PC to 4
        do_fetch(8'h01, 0);
        do_adv();
        do_fetch(8'h02, 1);
        do_adv();
        do_fetch(8'h03, 0);
        do_adv();
        chk("pc4_addr", imem_addr, 7'd4);

        // Branch in FETCH collides with ACK: ACK discarded
        br_taken  = 1'b1;
        br_target = 7'h20;
        imem_ack  = 1'b1;
        imem_data = 8'hFF;
        step();
        br_taken  = 1'b0;
        imem_ack  = 1'b0;
        exp_pc    = 7'h20;
        chk("brf_ir", ir, last_ir);
        chk("brf_valid", ir_valid, 1'b0);
        chk("brf_req", imem_req, 1'b1);
        chk("brf_addr", imem_addr, 7'h20);
        $display("branch in fetch -> addr=%02h ir=%02h", imem_addr, ir);

        // ACK outside FETCH ignored, then branch out of HOLD
        do_fetch(8'h44, 0);
        imem_ack  = 1'b1;
        imem_data = 8'hAA;
        step();
        imem_ack  = 1'b0;
        chk("ack_hold_ir", ir, 8'h44);
        chk("ack_hold_valid", ir_valid, 1'b1);
        br_taken  = 1'b1;
        br_target = 7'h7E;
        step();
        br_taken  = 1'b0;
        exp_pc    = 7'h7E;
        chk("brh_valid", ir_valid, 1'b0);
        chk("brh_req", imem_req, 1'b1);
        chk("brh_addr", imem_addr, 7'h7E);
        $display("branch in hold -> addr=%02h", imem_addr);

        // PC wrap at all-ones
        do_fetch(8'h10, 0);
        do_adv();
        do_fetch(8'h20, 2);
        chk("wrap_pc", imem_addr, 7'd0);
        do_adv();
        chk("wrap_req", imem_req, 1'b1);
        chk("wrap_addr", imem_addr, 7'd0);

        // HALT opcode
        do_fetch(8'hE3, 0);
        chk("halt_opc", opc, 3'b111);
        do_adv();
        chk("halt_halted", halted, 1'b1);
        chk("halt_req", imem_req, 1'b0);
        chk("halt_ir", ir, 8'hE3);
        br_taken  = 1'b1;
        br_target = 7'h33;
        imem_ack  = 1'b1;
        adv       = 1'b1;
        step();
        step();
        br_taken  = 1'b0;
        imem_ack  = 1'b0;
        adv       = 1'b0;
        chk("halt_stay", halted, 1'b1);
        chk("halt_stay_req", imem_req, 1'b0);
        chk("halt_stay_valid", ir_valid, 1'b0);
        $display("halt -> halted=%0b req=%0b", halted, imem_req);

        // Restart, then asynchronous reset in the middle of HOLD
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        exp_pc = 7'd0;
        step();
        do_fetch(8'h21, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ir_valid, 1'b0);
        chk("arst_ir", ir, 8'h00);
        chk("arst_req", imem_req, 1'b0);
        chk("arst_halted", halted, 1'b0);
        $display("async reset in hold -> valid=%0b ir=%02h", ir_valid, ir);
        step();
        rst_n = 1'b1;
        chk("rel_idle_req", imem_req, 1'b0);
        step();
        chk("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, 7'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the 3-to-8 opcode decoder.
- Owns the program counter and requests instructions from instruction memory over a REQ/ACK handshake.
- Holds the fetched word in an instruction register until the execute side consumes it.
- Drives the 3-bit opcode field OPC straight into decoder3_8's ENC input. Handles branch redirect, PC wrap and a terminal HALT state.

Parameters:
PC_W, 7, program counter / instruction address width
INSTR_W, 8, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-3]
RESET_PC, 0, PC value loaded on reset
HALT_OPC, 3'b111, opcode value that halts fetch after it is consumed

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
IMEM_REQ  out  1  fetch request, high while in FETCH
IMEM_ADDR  out  PC_W  fetch address, equals PC
IMEM_ACK  in  1  memory returns IMEM_DATA valid this cycle
IMEM_DATA  in  INSTR_W  instruction word
ADV  in  1  execute side consumes the held instruction this cycle
BR_TAKEN  in  1  redirect fetch to BR_TARGET
BR_TARGET  in  PC_W  redirect address
IR  out  INSTR_W  instruction register
IR_VALID  out  1  IR holds an unconsumed instruction
OPC  out  3  IR[INSTR_W-1:INSTR_W-3] when IR_VALID, else 3'b000; feeds decoder3_8 ENC
HALTED  out  1  fetch stopped

Behaviour:
- Reset (async assert, sync release): state=IDLE, PC=RESET_PC, IR=0, IR_VALID=0, IMEM_REQ=0, OPC=0, HALTED=0.
- States: IDLE, FETCH, HOLD, HALT. Outputs are Moore decodes of state: IMEM_REQ=(FETCH), IR_VALID=(HOLD), HALTED=(HALT).
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH: IMEM_ADDR=PC.
  - On IMEM_ACK: IR<=IMEM_DATA, PC<=PC+1 mod 2^PC_W (wraps all-ones -> 0), go to HOLD.
  - Without ACK: stay in FETCH; REQ and ADDR stay stable.
- HOLD, on ADV:
  - If IR opcode == HALT_OPC: go to HALT.
  - Otherwise: go to FETCH.
  - Either way, IR_VALID drops next cycle. IR keeps its value; OPC reads 0.
- HOLD without ADV: IR and PC are held indefinitely.
- Latencies:
  - ACK cycle -> IR_VALID high the next cycle.
  - ADV cycle -> IMEM_REQ high the next cycle.
  - Minimum 2 cycles per instruction.
- BR_TAKEN in FETCH or HOLD has top priority over ACK and ADV:
  - PC<=BR_TARGET, go to FETCH, IR_VALID drops.
  - Any ACK in the same cycle is discarded; IR is not written.
  - REQ stays high, with the new address from the next cycle.
- BR_TAKEN in IDLE or HALT: ignored.
- HALT: terminal; only RST_N exits. ACK, ADV and BR_TAKEN are ignored. REQ=0.
- ADV while IR_VALID=0: ignored.
- IMEM_ACK outside FETCH: ignored.
- Reset asserted mid-FETCH or mid-HOLD: all outputs go to reset values immediately (asynchronous). The in-flight request is abandoned.
- OPC is combinational from IR and state only; there is no path from any input to OPC.

Decomposition:
- Package fetch_pkg holds:
  - state enum (IDLE, FETCH, HOLD, HALT; 2-bit encoding)
  - OPC_W=3
  - the HALT_OPC default
  - a function extracting the opcode field from an instruction word
- No sub-module. The PC incrementer and FSM are inline. decoder3_8 is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then release with RESET_PC=0 -> IDLE for 1 cycle, then IMEM_REQ=1, IMEM_ADDR=0; IR_VALID=0 and OPC=0 throughout.
- ACK after a 3-cycle wait with DATA=8'h5A -> next cycle IR=8'h5A, IR_VALID=1, OPC=3'b010, PC=1; ADV -> REQ=1 with ADDR=1 the following cycle.
- In FETCH at PC=4, BR_TAKEN=1, BR_TARGET=7'h20, IMEM_ACK=1 in the same cycle -> IR unchanged, IR_VALID=0, next ADDR=7'h20, REQ still 1.
- PC=7'h7F, ACK -> PC wraps to 0; after ADV, ADDR=0.
- Fetch DATA=8'hE3 (opcode 3'b111), then ADV -> HALTED=1, REQ=0, OPC=0; later BR_TAKEN and ACK pulses leave state unchanged.
- In HOLD with IR=8'h21, assert RST_N=0 mid-cycle -> IR_VALID=0, IR=0, REQ=0 immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.
